// File: rtl/uart_inst_loader_pkg.sv
// ----------------------------------------------------------------------------
// uart_inst_loader_pkg
// Shared definitions for the serial program loader and its UART byte receiver.
//   rx_state_t      : receiver FSM state encoding (3-bit)
//   UART_DATA_BITS  : data bits per 8N1 frame
//   WORD_BYTES      : bytes per instruction word
// ----------------------------------------------------------------------------
package uart_inst_loader_pkg;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      START     = 3'd1,
      DATA      = 3'd2,
      STOP      = 3'd3,
      WAIT_HIGH = 3'd4
   } rx_state_t;

   localparam int UART_DATA_BITS = 8;
   localparam int WORD_BYTES     = 4;

endpackage

// File: rtl/uart_rx_byte.sv
// ----------------------------------------------------------------------------
// uart_rx_byte
// 8N1 UART byte receiver: 2-FF synchronizer, start/data/stop bit timing.
// Ports:
//   clk        in  system clock
//   rst        in  asynchronous active-low reset
//   rxd        in  serial line, asynchronous to clk, idle high
//   enable     in  0 holds the receiver in IDLE
//   byte_valid out one-cycle pulse in the cycle the good stop bit is sampled
//   byte_data  out received byte, valid while byte_valid is high
//   stop_err   out one-cycle pulse when the stop bit is sampled low
//   active     out FSM is not in IDLE
// ----------------------------------------------------------------------------
module uart_rx_byte
   import uart_inst_loader_pkg::*;
#(
   parameter int CLKS_PER_BIT = 434
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      rxd,
   input  logic                      enable,
   output logic                      byte_valid,
   output logic [UART_DATA_BITS-1:0] byte_data,
   output logic                      stop_err,
   output logic                      active
);

   localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
   localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [2:0]       LAST_BIT  = 3'(UART_DATA_BITS - 1);

   rx_state_t                 state, next_state;
   logic [CNT_W-1:0]          cnt, cnt_next;
   logic [2:0]                bit_idx, bit_next;
   logic [UART_DATA_BITS-1:0] shift, shift_next;
   logic                      sync1, sync2;
   logic                      rxd_s;

   // Synchronizer flops reset to the idle (high) line level so that
   // leaving reset never looks like a start bit.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync1 <= 1'b1;
         sync2 <= 1'b1;
      end else begin
         sync1 <= rxd;
         sync2 <= sync1;
      end
   end

   assign rxd_s = sync2;

   // FSM state and bit-timing registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= IDLE;
         cnt     <= '0;
         bit_idx <= '0;
         shift   <= '0;
      end else begin
         state   <= next_state;
         cnt     <= cnt_next;
         bit_idx <= bit_next;
         shift   <= shift_next;
      end
   end

   // Next-state logic. The line is looked at only on the counter terminal
   // counts inside START/DATA/STOP; byte_valid/stop_err are raised in the
   // sampling cycle so the loader can register the result on that same edge,
   // and the FSM is back in IDLE one clock after the stop sample, leaving
   // half a bit-time to catch a back-to-back start edge.
   always_comb begin
      next_state = state;
      cnt_next   = cnt + 1'b1;
      bit_next   = bit_idx;
      shift_next = shift;
      byte_valid = 1'b0;
      stop_err   = 1'b0;
      if (!enable) begin
         next_state = IDLE;
         cnt_next   = '0;
         bit_next   = '0;
      end else begin
         case (state)
            IDLE: begin
               cnt_next = '0;
               bit_next = '0;
               if (!rxd_s) next_state = START;
            end
            START: begin
               if (cnt == HALF_LAST) begin
                  cnt_next   = '0;
                  bit_next   = '0;
                  next_state = rxd_s ? IDLE : DATA;
               end
            end
            DATA: begin
               if (cnt == BIT_LAST) begin
                  cnt_next   = '0;
                  shift_next = {rxd_s, shift[UART_DATA_BITS-1:1]};
                  if (bit_idx == LAST_BIT) next_state = STOP;
                  else                     bit_next   = bit_idx + 1'b1;
               end
            end
            STOP: begin
               if (cnt == BIT_LAST) begin
                  cnt_next = '0;
                  if (rxd_s) begin
                     byte_valid = 1'b1;
                     next_state = IDLE;
                  end else begin
                     stop_err   = 1'b1;
                     next_state = WAIT_HIGH;
                  end
               end
            end
            WAIT_HIGH: begin
               // A held-low line (break) must not be taken as a new start bit.
               cnt_next = '0;
               if (rxd_s) next_state = IDLE;
            end
            default: begin
               next_state = IDLE;
               cnt_next   = '0;
            end
         endcase
      end
   end

   assign byte_data = shift;
   assign active    = (state != IDLE);

endmodule

// File: rtl/uart_inst_loader.sv
// ----------------------------------------------------------------------------
// uart_inst_loader
// Serial program loader: write side of the instruction memory. Assembles
// received UART bytes little-endian into 32-bit words and writes each word
// at a byte address that steps by 4, matching PC addressing.
// Ports:
//   clk        in  system clock
//   rst        in  asynchronous active-low reset
//   rxd        in  UART receive line, idle high
//   load_en    in  loader enable; 0 idles the receiver and clears address/index
//   wr_en      out one-cycle write strobe
//   wr_addr    out word byte address (multiple of 4), held between strobes
//   wr_data    out assembled word, held between strobes
//   busy       out frame or partial word in progress
//   frame_err  out sticky stop-bit error, cleared by reset or load_en rising
//   last_byte  out most recent good byte
// ----------------------------------------------------------------------------
module uart_inst_loader
   import uart_inst_loader_pkg::*;
#(
   parameter int CLK_FREQ = 50000000,
   parameter int BAUD     = 115200,
   parameter int ADDR_W   = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rxd,
   input  logic              load_en,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [31:0]       wr_data,
   output logic              busy,
   output logic              frame_err,
   output logic [7:0]        last_byte
);

   localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
   localparam logic [1:0] LAST_IDX = 2'(WORD_BYTES - 1);

   logic                      byte_valid;
   logic [UART_DATA_BITS-1:0] byte_data;
   logic                      stop_err;
   logic                      rx_active;
   logic [1:0]                byte_idx;
   logic [ADDR_W-1:0]         addr;
   logic [23:0]               word;
   logic                      load_en_q;

   uart_rx_byte #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_rx (
      .clk       (clk),
      .rst       (rst),
      .rxd       (rxd),
      .enable    (load_en),
      .byte_valid(byte_valid),
      .byte_data (byte_data),
      .stop_err  (stop_err),
      .active    (rx_active)
   );

   // Word assembly and address counter. Only the lower three bytes are
   // buffered; the fourth byte goes straight into wr_data with the strobe.
   // Dropping load_en throws away any partial word and restarts at address 0.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         byte_idx  <= '0;
         addr      <= '0;
         word      <= '0;
         wr_en     <= 1'b0;
         wr_addr   <= '0;
         wr_data   <= '0;
         last_byte <= '0;
      end else begin
         wr_en <= 1'b0;
         if (!load_en) begin
            byte_idx <= '0;
            addr     <= '0;
            word     <= '0;
         end else if (byte_valid) begin
            last_byte <= byte_data;
            case (byte_idx)
               2'd0: word[7:0]   <= byte_data;
               2'd1: word[15:8]  <= byte_data;
               2'd2: word[23:16] <= byte_data;
               default: ;
            endcase
            if (byte_idx == LAST_IDX) begin
               wr_en    <= 1'b1;
               wr_data  <= {byte_data, word};
               wr_addr  <= addr;
               addr     <= addr + ADDR_W'(4);
               byte_idx <= '0;
               word     <= '0;
            end else begin
               byte_idx <= byte_idx + 1'b1;
            end
         end
      end
   end

   // Sticky framing error; a fresh enable of the loader starts a clean session.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         load_en_q <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         load_en_q <= load_en;
         if (load_en && !load_en_q) frame_err <= 1'b0;
         else if (stop_err)         frame_err <= 1'b1;
      end
   end

   assign busy = load_en & (rx_active | (byte_idx != 2'd0));

endmodule

// File: tb/tb_uart_inst_loader.sv
// ----------------------------------------------------------------------------
// tb_uart_inst_loader
// Directed self-checking bench for uart_inst_loader with CLKS_PER_BIT = 10.
// ----------------------------------------------------------------------------
module tb_uart_inst_loader;

   localparam int CPB = 10;

   logic        clk;
   logic        rst;
   logic        rxd;
   logic        load_en;
   logic        wr_en;
   logic [7:0]  wr_addr;
   logic [31:0] wr_data;
   logic        busy;
   logic        frame_err;
   logic [7:0]  last_byte;

   int checks = 0;
   int errors = 0;
   int double_pulse = 0;
   logic prev_wr = 1'b0;

   typedef struct {
      logic [7:0]  addr;
      logic [31:0] data;
   } strobe_t;

   strobe_t strobes[$];

   uart_inst_loader #(
      .CLK_FREQ(1000),
      .BAUD    (100),
      .ADDR_W  (8)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .rxd      (rxd),
      .load_en  (load_en),
      .wr_en    (wr_en),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .busy     (busy),
      .frame_err(frame_err),
      .last_byte(last_byte)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Records every write strobe away from the active edge and flags any
   // strobe that lasts more than one cycle.
   always @(negedge clk) begin
      if (wr_en === 1'b1) begin
         strobes.push_back('{addr: wr_addr, data: wr_data});
         if (prev_wr === 1'b1) double_pulse++;
      end
      prev_wr = wr_en;
   end

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Sends one 8N1 frame starting at a negedge; ends on a negedge.
   task automatic applyStimulus(input logic [7:0] b, input logic stop_bit);
      logic [9:0] frame;
      frame = {stop_bit, b, 1'b0};
      for (int i = 0; i < 10; i++) begin
         rxd = frame[i];
         repeat (CPB) @(negedge clk);
      end
   endtask

   task automatic sendWord(input logic [31:0] w);
      applyStimulus(w[7:0], 1'b1);
      applyStimulus(w[15:8], 1'b1);
      applyStimulus(w[23:16], 1'b1);
      applyStimulus(w[31:24], 1'b1);
   endtask

   function automatic logic [31:0] wordFor(input int i);
      return {8'(i), 8'(i ^ 8'h5A), 8'(255 - i), 8'(i * 7)};
   endfunction

   initial begin
      logic [31:0] exp_w;
      rst = 1'b0;
      rxd = 1'b1;
      load_en = 1'b0;

      // 1. Reset with rxd toggling
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         rxd = ~rxd;
      end
      @(negedge clk);
      checkOutput("rst_wr_en", 32'(wr_en), 32'd0);
      checkOutput("rst_wr_addr", 32'(wr_addr), 32'd0);
      checkOutput("rst_wr_data", wr_data, 32'd0);
      checkOutput("rst_busy", 32'(busy), 32'd0);
      checkOutput("rst_frame_err", 32'(frame_err), 32'd0);
      checkOutput("rst_last_byte", 32'(last_byte), 32'd0);
      rxd = 1'b1;
      @(negedge clk);
      rst = 1'b1;
      load_en = 1'b1;
      repeat (20) @(negedge clk);
      checkOutput("idle_busy", 32'(busy), 32'd0);
      checkOutput("idle_no_strobe", 32'(strobes.size()), 32'd0);

      // 2. Single word
      sendWord(32'h00500093);
      repeat (5) @(negedge clk);
      checkOutput("single_count", 32'(strobes.size()), 32'd1);
      if (strobes.size() >= 1) begin
         checkOutput("single_data", strobes[0].data, 32'h00500093);
         checkOutput("single_addr", 32'(strobes[0].addr), 32'h00);
      end
      checkOutput("single_last_byte", 32'(last_byte), 32'h00);
      checkOutput("single_busy", 32'(busy), 32'd0);
      checkOutput("single_hold_data", wr_data, 32'h00500093);

      // 3. Back-to-back 65 words with address wrap
      load_en = 1'b0;
      @(negedge clk);
      load_en = 1'b1;
      @(negedge clk);
      strobes.delete();
      for (int i = 0; i < 65; i++) sendWord(wordFor(i));
      repeat (5) @(negedge clk);
      checkOutput("b2b_count", 32'(strobes.size()), 32'd65);
      if (strobes.size() == 65) begin
         for (int i = 0; i < 65; i++) begin
            checkOutput($sformatf("b2b_addr_%0d", i), 32'(strobes[i].addr), 32'((i * 4) % 256));
            checkOutput($sformatf("b2b_data_%0d", i), strobes[i].data, wordFor(i));
         end
      end
      checkOutput("b2b_last_byte", 32'(last_byte), 32'h40);

      // 4a. Glitch: 3-clock low pulse
      strobes.delete();
      rxd = 1'b0;
      repeat (3) @(negedge clk);
      rxd = 1'b1;
      repeat (30) @(negedge clk);
      checkOutput("glitch_no_strobe", 32'(strobes.size()), 32'd0);
      checkOutput("glitch_frame_err", 32'(frame_err), 32'd0);
      checkOutput("glitch_busy", 32'(busy), 32'd0);
      checkOutput("glitch_last_byte", 32'(last_byte), 32'h40);

      // 4b. Bad stop bit, line then held low (break)
      applyStimulus(8'hAA, 1'b0);
      repeat (20) @(negedge clk);
      checkOutput("ferr_set", 32'(frame_err), 32'd1);
      checkOutput("ferr_wait_high_busy", 32'(busy), 32'd1);
      checkOutput("ferr_no_strobe", 32'(strobes.size()), 32'd0);
      checkOutput("ferr_last_byte", 32'(last_byte), 32'h40);
      rxd = 1'b1;
      repeat (10) @(negedge clk);
      checkOutput("ferr_idx_unchanged", 32'(busy), 32'd0);

      // 4c. Recovery word at the post-wrap address
      sendWord(32'hCAFEF00D);
      repeat (5) @(negedge clk);
      checkOutput("recover_count", 32'(strobes.size()), 32'd1);
      if (strobes.size() >= 1) begin
         checkOutput("recover_data", strobes[0].data, 32'hCAFEF00D);
         checkOutput("recover_addr", 32'(strobes[0].addr), 32'h04);
      end
      checkOutput("recover_ferr_sticky", 32'(frame_err), 32'd1);

      // 5. Abort mid-byte via load_en
      strobes.delete();
      applyStimulus(8'h55, 1'b1);
      applyStimulus(8'h66, 1'b1);
      rxd = 1'b0;
      repeat (CPB) @(negedge clk);
      rxd = 1'b1;
      repeat (CPB + 5) @(negedge clk);
      checkOutput("abort_busy_mid", 32'(busy), 32'd1);
      load_en = 1'b0;
      @(negedge clk);
      load_en = 1'b1;
      repeat (30) @(negedge clk);
      checkOutput("abort_busy_after", 32'(busy), 32'd0);
      checkOutput("abort_ferr_cleared", 32'(frame_err), 32'd0);
      sendWord(32'h44332211);
      repeat (5) @(negedge clk);
      checkOutput("abort_count", 32'(strobes.size()), 32'd1);
      if (strobes.size() >= 1) begin
         checkOutput("abort_data", strobes[0].data, 32'h44332211);
         checkOutput("abort_addr", 32'(strobes[0].addr), 32'h00);
      end

      // 6. Asynchronous reset during DATA bit 4
      applyStimulus(8'h77, 1'b1);
      checkOutput("pre_rst_last_byte", 32'(last_byte), 32'h77);
      exp_w = 32'h0000003C;
      rxd = 1'b0;
      repeat (CPB) @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         rxd = exp_w[i];
         repeat (CPB) @(negedge clk);
      end
      rxd = exp_w[4];
      repeat (5) @(negedge clk);
      #2 rst = 1'b0;
      #1;
      checkOutput("arst_wr_en", 32'(wr_en), 32'd0);
      checkOutput("arst_wr_addr", 32'(wr_addr), 32'd0);
      checkOutput("arst_wr_data", wr_data, 32'd0);
      checkOutput("arst_busy", 32'(busy), 32'd0);
      checkOutput("arst_frame_err", 32'(frame_err), 32'd0);
      checkOutput("arst_last_byte", 32'(last_byte), 32'd0);
      @(negedge clk);
      rxd = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      repeat (20) @(negedge clk);
      strobes.delete();
      sendWord(32'h13579BDF);
      repeat (5) @(negedge clk);
      checkOutput("arst_count", 32'(strobes.size()), 32'd1);
      if (strobes.size() >= 1) begin
         checkOutput("arst_next_data", strobes[0].data, 32'h13579BDF);
         checkOutput("arst_next_addr", 32'(strobes[0].addr), 32'h00);
      end

      checkOutput("single_cycle_strobes", 32'(double_pulse), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/uart_inst_loader.md
Name: uart_inst_loader

Overview:
- Serial program loader; the write side of the instruction memory, which the datapath only reads via PC.
- Receives 8N1 UART bytes on UART_RXD and assembles them little-endian into 32-bit instruction words.
- Emits one write strobe per word, with a byte address that matches PC addressing (PC steps by 4).
- Lets a program be downloaded into instruction memory without resynthesis.

Parameters:
- CLK_FREQ, 50000000, clock frequency in Hz.
- BAUD, 115200, line rate in bit/s.
- CLKS_PER_BIT, CLK_FREQ/BAUD (434), clocks per bit; derived localparam.
- ADDR_W, 8, width of the instruction address (matches 8-bit PC).

Ports:
- clk  in  1  system clock (CLOCK_50).
- rst  in  1  asynchronous active-low reset.
- rxd  in  1  UART_RXD, asynchronous to clk; idle high.
- load_en  in  1  loader enable. When 0, the receiver is held idle and the address/byte index are cleared.
- wr_en  out  1  one-cycle write strobe to instruction memory.
- wr_addr  out  ADDR_W  byte address of the word; always a multiple of 4.
- wr_data  out  32  assembled instruction word.
- busy  out  1  a frame or a partial word is in progress.
- frame_err  out  1  sticky: a stop bit was sampled low.
- last_byte  out  8  most recent good byte, for LCD debug.

Behaviour:
- Reset (rst=0, asynchronous): all outputs 0, FSM in IDLE, byte_idx=0, addr=0, synchronizer flops=1.
- rxd passes through a 2-FF synchronizer (2 clk latency); all FSM decisions use the synchronized value.
- FSM states and transitions:
  - IDLE: wait for synchronized rxd=0 with load_en=1, then go to START with the bit counter cleared.
  - START: at CLKS_PER_BIT/2 clocks, resample. If rxd=1, treat as a glitch and return to IDLE with no error. If rxd=0, go to DATA with bit_idx=0 and the counter cleared.
  - DATA: sample every CLKS_PER_BIT clocks (mid-bit), LSB first, into a shift register. After bit 7, go to STOP.
  - STOP: after CLKS_PER_BIT clocks, sample.
    - rxd=1: byte accepted and last_byte updated; go to IDLE.
    - rxd=0: frame_err<=1, byte discarded, byte_idx unchanged; go to WAIT_HIGH.
  - WAIT_HIGH: stay until synchronized rxd=1, then go to IDLE. Prevents a break condition from being read as a new start bit.
- Word assembly:
  - Accepted byte k (byte_idx=k) is written to word bits [8k+7:8k] (little-endian, k=0..3).
  - byte_idx increments per accepted byte.
  - On the 4th byte, in the clock after the STOP sample:
    - wr_en=1 for exactly 1 cycle, with wr_data = the complete word and wr_addr = current addr.
    - addr += 4, wrapping modulo 2^ADDR_W (252 -> 0 for ADDR_W=8).
    - byte_idx returns to 0.
- wr_data and wr_addr hold their values until the next strobe.
- busy = load_en & (state != IDLE | byte_idx != 0).
- load_en deasserted at any time (including mid-frame): the next clock forces IDLE, and byte_idx, addr and the partial word are cleared. A partial word is never written and wr_en stays 0.
- frame_err is cleared only by reset or by a rising edge of load_en.
- Throughput: one byte per 10 bit-times. The FSM re-arms in IDLE within 1 clock of the STOP sample, so back-to-back frames with no idle gap are received correctly.
- rxd is never sampled while the FSM is in START/DATA/STOP except at the scheduled sample points.

Decomposition:
- Shared package/include holds:
  - state encodings IDLE/START/DATA/STOP/WAIT_HIGH (3-bit);
  - UART_DATA_BITS=8;
  - WORD_BYTES=4.
- One sub-module, uart_rx_byte: synchronizer, FSM and bit timing, with outputs byte_valid (1-cycle pulse), byte_data and stop_err.
- The top loader keeps only word assembly, address counter, frame_err and busy.
- Later reuse: a uart_tx block pairs with uart_rx_byte for UART_TXD.

Test Plan:
All scenarios run with CLK_FREQ=1000 and BAUD=100, giving CLKS_PER_BIT=10.
1. Reset: hold rst=0 with rxd toggling -> wr_en=0, wr_addr=0, wr_data=0, busy=0, frame_err=0; after release the FSM stays IDLE while rxd=1.
2. Single word: load_en=1, send bytes 0x93,0x00,0x50,0x00 -> exactly one wr_en pulse, wr_data=0x00500093, wr_addr=0x00, last_byte=0x00, busy=0 afterwards.
3. Back-to-back with wrap: send 65 words with no idle gap between frames -> 65 strobes at addresses 0x00,0x04,...,0xFC, then 0x00 again; each wr_data matches its sent word.
4. Glitch and framing error:
   - A 3-clock low pulse on rxd -> no byte, no error.
   - A frame with stop bit 0 (data 0xAA) -> frame_err=1, byte_idx unchanged, no strobe; the FSM waits for rxd high.
   - Then the next 4 good bytes -> one correct word.
5. Abort: send 2 bytes, drop load_en for 1 clock mid-way through byte 3, re-enable, then send 4 bytes 0x11,0x22,0x33,0x44 -> a single strobe with wr_data=0x44332211, wr_addr=0x00, and frame_err cleared.
6. Async reset mid-frame: assert rst during DATA bit 4 -> all outputs 0 immediately (before the next clk edge); the partial byte is lost and the next full word is written at address 0.
